// File: rtl/div_if.sv
//------------------------------------------------------------------------------
// Module : div_if
// Brief  : Request/response bundle between the decode stage and the divider.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface div_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      reg_wr_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            ready_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      reg_wr_addr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_wr_addr_i, flush_i,
    input  busy_o, ready_o, result_o, reg_wr_addr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_wr_addr_i, flush_i,
    output busy_o, ready_o, result_o, reg_wr_addr_o
  );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
//------------------------------------------------------------------------------
// Module : div_unit
// Brief  : RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient bit/cycle.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_unit #(
  parameter int XLEN = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  div_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] C_ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [4:0]      C_LAST_CNT = 5'd31;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic              w_div0;
  logic              w_ovf;
  logic              w_accept;
  logic [XLEN:0]     w_trial;
  logic              w_qbit;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_quo_next;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_final;

  // op_i[0] clear selects the signed forms (DIV/REM)
  assign w_signed = ~bus.op_i[0];
  assign w_a_neg  = w_signed & bus.dividend_i[XLEN-1];
  assign w_b_neg  = w_signed & bus.divisor_i[XLEN-1];
  assign w_a_abs  = w_a_neg ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
  assign w_b_abs  = w_b_neg ? (~bus.divisor_i + 1'b1) : bus.divisor_i;
  assign w_div0   = (bus.divisor_i == '0);
  assign w_ovf    = w_signed && (bus.dividend_i == C_INT_MIN) && (bus.divisor_i == C_ALL_ONES);
  assign w_accept = bus.start_i && !bus.flush_i && (state_q == S_IDLE || state_q == S_DONE);

  // The shifted partial remainder needs one extra bit so the borrow is visible
  assign w_trial    = {rem_q, dvd_q[XLEN-1]} - {1'b0, dvs_q};
  assign w_qbit     = ~w_trial[XLEN];
  assign w_rem_next = w_qbit ? w_trial[XLEN-1:0] : {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
  assign w_quo_next = {dvd_q[XLEN-2:0], w_qbit};
  assign w_quo_fix  = qneg_q ? (~w_quo_next + 1'b1) : w_quo_next;
  assign w_rem_fix  = rneg_q ? (~w_rem_next + 1'b1) : w_rem_next;
  assign w_final    = op_q[1] ? w_rem_fix : w_quo_fix;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (w_accept) begin
          op_d   = bus.op_i;
          rd_d   = bus.reg_wr_addr_i;
          dvd_d  = w_a_abs;
          dvs_d  = w_b_abs;
          rem_d  = '0;
          cnt_d  = '0;
          qneg_d = w_a_neg ^ w_b_neg;
          rneg_d = w_a_neg;
          if (w_div0) begin
            result_d = bus.op_i[1] ? bus.dividend_i : C_ALL_ONES;
            rd_out_d = bus.reg_wr_addr_i;
            state_d  = S_DONE;
          end else if (w_ovf) begin
            result_d = bus.op_i[1] ? '0 : C_INT_MIN;
            rd_out_d = bus.reg_wr_addr_i;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = w_rem_next;
        dvd_d = w_quo_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == C_LAST_CNT) begin
          result_d = w_final;
          rd_out_d = rd_q;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts without touching the architecturally visible result
    if (bus.flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign bus.busy_o        = (state_q == S_CALC);
  assign bus.ready_o       = (state_q == S_DONE);
  assign bus.result_o      = result_q;
  assign bus.reg_wr_addr_o = rd_out_q;

endmodule

`default_nettype wire
